// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and helpers for the I2S input front end
package i2s_pkg;

  // Width of the per-half shift counter and the bits_per_half report
  localparam int BITCNT_W = 6;

  // Front-end link states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ACQUIRE = 2'd1;
  localparam state_t ST_LOCKED  = 2'd2;

  // Saturating increment so a runaway half reports 63 instead of wrapping
  function automatic logic [BITCNT_W-1:0] bitcnt_inc(input logic [BITCNT_W-1:0] v);
    return (v == {BITCNT_W{1'b1}}) ? v : v + BITCNT_W'(1);
  endfunction

endpackage

// File: rtl/i2s_sync.sv
// rtl/i2s_sync.sv - multi-stage single-bit synchronizer with async reset
module i2s_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through STAGES flops into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/i2s_strobe_gen.sv
// rtl/i2s_strobe_gen.sv - I2S input sync, shift/load strobes and frame lock tracking
module i2s_strobe_gen
  import i2s_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_BITS     = 16,
  parameter int MAX_BITS     = 32,
  parameter int LOCK_HALVES  = 4,
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i2s_bclk,
  input  logic                i2s_lrclk,
  input  logic                i2s_data,
  output logic                i2s_lrclk_s,
  output logic                i2s_data_s,
  output logic                i2s_data_shift_strobe,
  output logic                i2s_data_load_strobe,
  output logic                locked,
  output logic                frame_error,
  output logic [BITCNT_W-1:0] bits_per_half
);

  localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam int TMO_W   = $clog2(TIMEOUT_CLKS + 1);
  localparam int GOOD_W  = $clog2(LOCK_HALVES + 1);

  logic                bclk_s;
  logic                bclk_prev;
  logic                lrclk_prev;
  logic [PRIME_W-1:0]  prime_cnt;
  logic                primed;
  logic                shift;
  logic                lr_edge;
  logic                pending;
  logic                load_arm;
  logic                load;
  logic                timeout;
  logic                half_good;
  logic                have_prev;
  logic [BITCNT_W-1:0] bit_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [GOOD_W-1:0]   good_cnt;
  state_t              state;

  // Same depth on all three inputs keeps bclk, lrclk and data mutually aligned
  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk   (clk),
    .reset (reset),
    .d     (i2s_bclk),
    .q     (bclk_s)
  );

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_lrclk (
    .clk   (clk),
    .reset (reset),
    .d     (i2s_lrclk),
    .q     (i2s_lrclk_s)
  );

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk   (clk),
    .reset (reset),
    .d     (i2s_data),
    .q     (i2s_data_s)
  );

  // Previous-value flops for edge detection, plus a short priming count so the
  // zeros left in the chains by reset are never mistaken for a real edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_prev  <= 1'b0;
      lrclk_prev <= 1'b0;
      prime_cnt  <= '0;
    end else begin
      bclk_prev  <= bclk_s;
      lrclk_prev <= i2s_lrclk_s;
      if (!primed) begin
        prime_cnt <= prime_cnt + PRIME_W'(1);
      end
    end
  end

  assign primed  = (prime_cnt == PRIME_W'(SYNC_STAGES + 1));
  assign shift   = primed && bclk_s && !bclk_prev;
  assign lr_edge = primed && (i2s_lrclk_s != lrclk_prev);
  assign timeout = !shift && (tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));
  assign load    = load_arm && (state != ST_IDLE);

  // A half is good when its length is in range and matches the previous half
  assign half_good = have_prev
                  && (bit_cnt >= BITCNT_W'(MIN_BITS))
                  && (bit_cnt <= BITCNT_W'(MAX_BITS))
                  && (bit_cnt == bits_per_half);

  assign i2s_data_shift_strobe = shift;
  assign i2s_data_load_strobe  = load;
  assign locked                = (state == ST_LOCKED);
  assign frame_error           = load && (state == ST_LOCKED) && !half_good;

  // Pending load: the first rise after an lrclk edge carries the old word's
  // LSB, so the load fires one clk after that rise once the shift has landed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= 1'b0;
      load_arm <= 1'b0;
    end else if (timeout) begin
      pending  <= 1'b0;
      load_arm <= 1'b0;
    end else begin
      load_arm <= shift && (pending || lr_edge);
      if (lr_edge) begin
        pending <= 1'b1;
      end else if (load_arm) begin
        pending <= 1'b0;
      end
    end
  end

  // Count shifts per half and publish the length at each load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt       <= '0;
      bits_per_half <= '0;
    end else if (timeout) begin
      bit_cnt <= '0;
    end else if (load) begin
      bits_per_half <= bit_cnt;
      bit_cnt       <= '0;
    end else if (shift) begin
      bit_cnt <= bitcnt_inc(bit_cnt);
    end
  end

  // Idle watchdog: restarts on every bclk rise, saturates once expired
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (shift) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_W'(TIMEOUT_CLKS)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Lock state machine; timeout overrides any load evaluation in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      good_cnt  <= '0;
      have_prev <= 1'b0;
    end else if (timeout) begin
      state     <= ST_IDLE;
      good_cnt  <= '0;
      have_prev <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (shift) begin
            state <= ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (load) begin
            have_prev <= 1'b1;
            if (half_good) begin
              good_cnt <= good_cnt + GOOD_W'(1);
              if (good_cnt == GOOD_W'(LOCK_HALVES - 1)) begin
                state <= ST_LOCKED;
              end
            end else begin
              good_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (load) begin
            have_prev <= 1'b1;
            if (!half_good) begin
              good_cnt <= '0;
              state    <= ST_ACQUIRE;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          good_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_strobe_gen.sv
// tb/tb_i2s_strobe_gen.sv - directed self-checking bench for i2s_strobe_gen
module tb_i2s_strobe_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bclk = 1'b0;
  logic       lrclk = 1'b0;
  logic       data = 1'b0;
  logic       lrclk_s, data_s, shift, load, locked, fe;
  logic [5:0] bph;

  i2s_strobe_gen dut (
    .clk                   (clk),
    .reset                 (reset),
    .i2s_bclk              (bclk),
    .i2s_lrclk             (lrclk),
    .i2s_data              (data),
    .i2s_lrclk_s           (lrclk_s),
    .i2s_data_s            (data_s),
    .i2s_data_shift_strobe (shift),
    .i2s_data_load_strobe  (load),
    .locked                (locked),
    .frame_error           (fe),
    .bits_per_half         (bph)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] W_L = 32'hA5C3_0000;
  localparam logic [31:0] W_R = 32'h1234_0000;
  localparam logic [31:0] W_S = 32'hF0F0_0000;
  localparam logic [31:0] W_1 = 32'hFFFF_FFFF;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Receiver model and protocol monitor, sampled on the falling clk edge
  int          cyc = 0;
  int          load_count = 0;
  int          fe_total = 0;
  int          fe_orphan = 0;
  int          coincide = 0;
  int          gap_bad = 0;
  int          lock_at_load = 0;
  int          last_shift_cyc = 0;
  int          fall_cyc = 0;
  logic        prev_shift = 1'b0;
  logic        locked_d = 1'b0;
  logic [31:0] shreg = '0;
  logic [31:0] word_l = '0;
  logic [31:0] word_r = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      prev_shift <= 1'b0;
      locked_d   <= 1'b0;
    end else begin
      prev_shift <= shift;
      locked_d   <= locked;
      if (shift) begin
        shreg          <= {shreg[30:0], data_s};
        last_shift_cyc <= cyc;
      end
      if (load) begin
        load_count <= load_count + 1;
        if (lrclk_s) word_l <= shreg;
        else         word_r <= shreg;
        if (shift)       coincide <= coincide + 1;
        if (!prev_shift) gap_bad  <= gap_bad + 1;
      end
      if (fe) begin
        fe_total <= fe_total + 1;
        if (!load) fe_orphan <= fe_orphan + 1;
      end
      if (locked && !locked_d && lock_at_load == 0) lock_at_load <= load_count;
      if (!locked && locked_d) fall_cyc <= cyc;
    end
  end

  logic lsb_carry = 1'b0;

  // One bclk period: 9 clks low then 9 clks high, lrclk/data change with the fall
  task automatic bclk_cycle(input logic lr, input logic d);
    bclk  = 1'b0;
    lrclk = lr;
    data  = d;
    repeat (9) @(negedge clk);
    bclk = 1'b1;
    repeat (9) @(negedge clk);
  endtask

  // Slot position 0 carries the previous word's LSB (I2S one-bit delay)
  task automatic send_bits(input logic ch, input int n, input logic [31:0] w,
                           input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (i == 0) bclk_cycle(ch, lsb_carry);
      else        bclk_cycle(ch, w[32-i]);
    end
    if (last == n - 1) lsb_carry = w[32-n];
  endtask

  task automatic send_half(input logic ch, input int n, input logic [31:0] w);
    send_bits(ch, n, w, 0, n - 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lrclk_s"}, int'(lrclk_s), 0);
    check({tag, "_data_s"},  int'(data_s),  0);
    check({tag, "_shift"},   int'(shift),   0);
    check({tag, "_load"},    int'(load),    0);
    check({tag, "_locked"},  int'(locked),  0);
    check({tag, "_ferr"},    int'(fe),      0);
    check({tag, "_bph"},     int'(bph),     0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  int ld_snap;

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Five stereo frames starting with L; first lrclk edge at half 2.
    // Load 1 sees 33 shifts (no previous length), load 2 sees 32 vs 33,
    // loads 3..6 are good, so locked rises right after load 6.
    for (int f = 0; f < 5; f++) begin
      send_half(1'b0, 32, W_L);
      send_half(1'b1, 32, W_R);
    end
    check("t1_locked",       int'(locked), 1);
    check("t1_lock_at_load", lock_at_load, 6);
    check("t1_bph",          int'(bph),    32);
    check("t1_word_l",       int'(word_l), int'(W_L));
    check("t1_word_r",       int'(word_r), int'(W_R));
    check("t2_loads_per_edge", load_count, 9);
    check("t2_coincident",   coincide,     0);
    check("t2_gap",          gap_bad,      0);
    check("t1_ferr",         fe_total,     0);

    // Short 20-bit half while locked, then recovery
    send_half(1'b0, 32, W_L);
    send_half(1'b1, 20, W_R);
    send_half(1'b0, 32, W_L);
    check("t3_ferr_count",  fe_total,     1);
    check("t3_ferr_orphan", fe_orphan,    0);
    check("t3_unlocked",    int'(locked), 0);
    check("t3_bph",         int'(bph),    20);
    send_half(1'b1, 32, W_R);
    send_half(1'b0, 32, W_L);
    send_half(1'b1, 32, W_R);
    send_half(1'b0, 32, W_L);
    check("t3_not_yet",     int'(locked), 0);
    send_half(1'b1, 32, W_R);
    check("t3_relocked",    int'(locked), 1);

    // bclk stall mid-half: counter clears the edge after the strobe cycle and
    // expires 1024 edges later, so locked is seen low 1025 clks after it
    send_bits(1'b0, 32, W_L, 0, 9);
    check("t4_locked_before", int'(locked), 1);
    ld_snap = load_count;
    bclk = 1'b0;
    repeat (1100) @(negedge clk);
    check("t4_unlocked",     int'(locked),            0);
    check("t4_idle_delay",   fall_cyc - last_shift_cyc, 1025);
    check("t4_no_load",      load_count,              ld_snap);
    send_bits(1'b0, 32, W_L, 10, 31);
    send_half(1'b1, 32, W_R);
    check("t4_restart_load", load_count,   ld_snap + 1);
    check("t4_restart_bph",  int'(bph),    23);
    check("t4_still_unlocked", int'(locked), 0);

    // Ten 12-bit halves
    for (int h = 0; h < 10; h++) send_half(h[0], 12, W_S);
    check("t5_locked", int'(locked), 0);
    check("t5_bph",    int'(bph),    12);
    check("t5_ferr",   fe_total,     1);

    // Reset during bit 9 of a right half
    send_bits(1'b1, 32, W_1, 0, 7);
    bclk  = 1'b0;
    lrclk = 1'b1;
    data  = W_1[24];
    repeat (9) @(negedge clk);
    bclk = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_pre_lrclk_s", int'(lrclk_s), 1);
    check("t6_pre_data_s",  int'(data_s),  1);
    ld_snap = load_count;
    reset = 1'b1;
    #1;
    check_all_zero("t6_reset");
    @(negedge clk);
    bclk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    send_bits(1'b1, 32, W_1, 9, 31);
    check("t6_no_load_wo_edge", load_count, ld_snap);
    send_half(1'b0, 32, W_L);
    check("t6_load_after_edge", load_count,   ld_snap + 1);
    check("t6_bph",             int'(bph),    24);
    check("t6_locked",          int'(locked), 0);
    check("t6_ferr",            fe_total,     1);
    check("end_coincident",     coincide,     0);
    check("end_gap",            gap_bad,      0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
